// File: rtl/zspi_ports.sv
`default_nettype none
// ============================================================================
// Module   : zspi_ports
// Purpose  : Z80 I/O-port SPI master (mode 0, programmable SCK) with NCS
//            chip selects, busy/overrun status and read-triggered exchanges.
// Revision : 1.0 - initial release
// ============================================================================
module zspi_ports #(
    parameter logic [7:0] CFG_PORT = 8'h77,
    parameter logic [7:0] DAT_PORT = 8'h57,
    parameter logic [7:0] DIV_PORT = 8'h37,
    parameter int         NCS      = 2,
    parameter logic [7:0] DIV_RST  = 8'd3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [7:0]     a,
    input  logic [7:0]     din,
    output logic [7:0]     dout,
    input  logic           iorq_n,
    input  logic           rd_n,
    input  logic           wr_n,
    output logic [NCS-1:0] cs_n,
    output logic           sck,
    output logic           mosi,
    input  logic           miso,
    output logic           busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    localparam int c_WR_CFG = 0;
    localparam int c_RD_CFG = 1;
    localparam int c_WR_DIV = 2;
    localparam int c_WR_DAT = 3;
    localparam int c_RD_DAT = 4;

    logic [4:0]     w_strb;
    logic [4:0]     r_strb;
    logic [4:0]     w_rise;
    logic           w_cfg_rd_end;
    logic           w_dat_go;

    state_t         r_state;
    logic [NCS-1:0] r_cs_n;
    logic [7:0]     r_div;
    logic [7:0]     r_dact;
    logic [7:0]     r_cnt;
    logic [2:0]     r_bit;
    logic [7:0]     r_sh;
    logic [7:0]     r_rx;
    logic [7:0]     r_rx_data;
    logic           r_sck;
    logic           r_mosi;
    logic           r_busy;
    logic           r_ovr;

    assign w_strb[c_WR_CFG] = (a == CFG_PORT) & ~iorq_n & ~wr_n;
    assign w_strb[c_RD_CFG] = (a == CFG_PORT) & ~iorq_n & ~rd_n;
    assign w_strb[c_WR_DIV] = (a == DIV_PORT) & ~iorq_n & ~wr_n;
    assign w_strb[c_WR_DAT] = (a == DAT_PORT) & ~iorq_n & ~wr_n;
    assign w_strb[c_RD_DAT] = (a == DAT_PORT) & ~iorq_n & ~rd_n;

    assign w_rise       = w_strb & ~r_strb;
    // Overrun is cleared once the status access ends, so the Z80 still sees it set.
    assign w_cfg_rd_end = r_strb[c_RD_CFG] & ~w_strb[c_RD_CFG];
    assign w_dat_go     = w_rise[c_WR_DAT] | w_rise[c_RD_DAT];

    always_comb begin
        dout = 8'hFF;
        if (a == CFG_PORT) begin
            dout           = 8'h00;
            dout[7]        = r_busy;
            dout[6]        = r_ovr;
            dout[NCS-1:0]  = r_cs_n;
        end else if (a == DAT_PORT) begin
            dout = r_rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_strb    <= '0;
            r_state   <= ST_IDLE;
            r_cs_n    <= '1;
            r_div     <= DIV_RST;
            r_dact    <= DIV_RST;
            r_cnt     <= 8'd0;
            r_bit     <= 3'd0;
            r_sh      <= 8'hFF;
            r_rx      <= 8'hFF;
            r_rx_data <= 8'hFF;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b1;
            r_busy    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_strb <= w_strb;

            if (w_rise[c_WR_CFG]) begin
                r_cs_n <= din[NCS-1:0];
            end

            if (w_cfg_rd_end) begin
                r_ovr <= 1'b0;
            end
            if (w_rise[c_WR_DIV]) begin
                if (r_busy) begin
                    r_ovr <= 1'b1;
                end else begin
                    r_div <= din;
                end
            end
            if (w_dat_go && r_busy) begin
                r_ovr <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_dat_go) begin
                        // A write supplies the byte; a read clocks out all ones.
                        r_sh    <= w_rise[c_WR_DAT] ? din    : 8'hFF;
                        r_mosi  <= w_rise[c_WR_DAT] ? din[7] : 1'b1;
                        r_cnt   <= 8'd0;
                        r_bit   <= 3'd0;
                        r_dact  <= r_div;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (r_cnt == r_dact) begin
                        r_sck   <= 1'b1;
                        r_rx    <= {r_rx[6:0], miso};
                        r_cnt   <= 8'd0;
                        r_state <= ST_HIGH;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (r_cnt == r_dact) begin
                        r_sck <= 1'b0;
                        r_cnt <= 8'd0;
                        if (r_bit == 3'd7) begin
                            r_rx_data <= r_rx;
                            r_busy    <= 1'b0;
                            r_mosi    <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_sh    <= {r_sh[6:0], 1'b0};
                            r_mosi  <= r_sh[6];
                            r_bit   <= r_bit + 3'd1;
                            r_state <= ST_LOW;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cs_n = r_cs_n;
    assign sck  = r_sck;
    assign mosi = r_mosi;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_zspi_ports.sv
`default_nettype none
// ============================================================================
// Module   : tb_zspi_ports
// Purpose  : Scoreboard bench for zspi_ports: bus reads and SPI exchanges are
//            queued by stimulus and checked by independent monitors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zspi_ports;

    localparam logic [7:0] c_CFG = 8'h77;
    localparam logic [7:0] c_DAT = 8'h57;
    localparam logic [7:0] c_DIV = 8'h37;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [7:0] a      = 8'h00;
    logic [7:0] din    = 8'h00;
    logic [7:0] dout;
    logic       iorq_n = 1'b1;
    logic       rd_n   = 1'b1;
    logic       wr_n   = 1'b1;
    logic [1:0] cs_n;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic       busy;

    logic       loop     = 1'b1;
    logic [7:0] slave_sh = 8'h00;

    zspi_ports dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .din    (din),
        .dout   (dout),
        .iorq_n (iorq_n),
        .rd_n   (rd_n),
        .wr_n   (wr_n),
        .cs_n   (cs_n),
        .sck    (sck),
        .mosi   (mosi),
        .miso   (miso),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Mode-0 slave: either loop mosi back or shift out slave_sh MSB first.
    assign miso = loop ? mosi : slave_sh[7];
    always @(negedge sck) slave_sh <= {slave_sh[6:0], 1'b0};

    typedef struct {
        logic [7:0] mosi_byte;
        int         dur;
        int         hi;
    } xexp_t;

    xexp_t      xq[$];
    logic [7:0] rq[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- monitors ----------------
    int         cyc = 0;
    bit         in_x = 1'b0;
    int         t0, hi_cnt, nbits;
    logic [7:0] mb;
    bit         prev_busy = 1'b0;
    bit         prev_sck  = 1'b0;
    bit         abort     = 1'b0;
    int         n_starts  = 0;
    bit         rd_seen   = 1'b0;
    xexp_t      e;
    logic [7:0] er;

    always @(negedge clk) begin
        cyc++;
        if (busy === 1'b1 && !prev_busy) begin
            in_x = 1'b1; t0 = cyc; hi_cnt = 0; nbits = 0; mb = 8'h00;
            n_starts++;
        end
        if (in_x && busy === 1'b1) begin
            if (sck === 1'b1) hi_cnt++;
            if (sck === 1'b1 && !prev_sck) begin
                mb = {mb[6:0], mosi};
                nbits++;
            end
        end
        if (in_x && busy !== 1'b1) begin
            in_x = 1'b0;
            if (abort) begin
                abort = 1'b0;
            end else begin
                check("xq_nonempty", xq.size() != 0, 1);
                if (xq.size() != 0) begin
                    e = xq.pop_front();
                    check("x_mosi", mb, e.mosi_byte);
                    check("x_duration", cyc - t0, e.dur);
                    check("x_sck_high", hi_cnt, e.hi);
                    check("x_pulses", nbits, 8);
                end
            end
        end
        prev_busy = (busy === 1'b1);
        prev_sck  = (sck === 1'b1);

        if (!iorq_n && !rd_n) begin
            if (!rd_seen) begin
                rd_seen = 1'b1;
                check("rq_nonempty", rq.size() != 0, 1);
                if (rq.size() != 0) begin
                    er = rq.pop_front();
                    check("rd_dout", dout, er);
                end
            end
        end else begin
            rd_seen = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic io(input logic [7:0] addr, input logic [7:0] data, input bit is_wr, input int n);
        @(posedge clk); #1;
        a = addr; din = data; iorq_n = 1'b0;
        if (is_wr) wr_n = 1'b0; else rd_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        iorq_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; a = 8'h00;
    endtask

    task automatic push_x(input logic [7:0] m, input int d, input int h);
        xexp_t x;
        x.mosi_byte = m; x.dur = d; x.hi = h;
        xq.push_back(x);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        check("wait_idle", busy, 0);
    endtask

    int s;

    initial begin
        // 1: reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_cs_n", cs_n, 2'b11);
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 1);
        check("rst_busy", busy, 0);
        rq.push_back(8'h03); io(c_CFG, 8'h00, 0, 2);
        rq.push_back(8'hFF); io(c_DAT, 8'h00, 0, 2);
        push_x(8'hFF, 64, 32); wait_idle();

        // 2: div 0, loopback write
        io(c_DIV, 8'h00, 1, 1);
        io(c_CFG, 8'h02, 1, 1);
        check("cfg_cs_n", cs_n, 2'b10);
        loop = 1'b1;
        push_x(8'hA5, 16, 8);
        io(c_DAT, 8'hA5, 1, 1);
        wait_idle();

        // 3: read-triggered exchange with slave data 3C
        loop = 1'b0; slave_sh = 8'h3C;
        push_x(8'hFF, 16, 8); rq.push_back(8'hA5);
        io(c_DAT, 8'h00, 0, 1);
        wait_idle();
        slave_sh = 8'h00;
        push_x(8'hFF, 16, 8); rq.push_back(8'h3C);
        io(c_DAT, 8'h00, 0, 1);
        wait_idle();

        // 4: div 4 -> 5-clk half periods
        loop = 1'b1;
        io(c_DIV, 8'h04, 1, 1);
        push_x(8'h00, 80, 40);
        io(c_DAT, 8'h00, 1, 1);
        wait_idle();

        // 5: overrun from DAT and DIV writes during busy
        push_x(8'h5A, 80, 40);
        io(c_DAT, 8'h5A, 1, 1);
        io(c_DAT, 8'h77, 1, 1);
        io(c_DIV, 8'h00, 1, 1);
        rq.push_back(8'hC2); io(c_CFG, 8'h00, 0, 2);
        wait_idle();
        rq.push_back(8'h02); io(c_CFG, 8'h00, 0, 2);
        push_x(8'hFF, 80, 40); rq.push_back(8'h5A);
        io(c_DAT, 8'h00, 0, 1);
        wait_idle();

        // 6: long strobe gives one exchange; reset mid-exchange
        io(c_DIV, 8'h00, 1, 1);
        push_x(8'hC3, 16, 8);
        s = n_starts;
        io(c_DAT, 8'hC3, 1, 6);
        wait_idle();
        check("one_exchange", n_starts - s, 1);
        rq.push_back(8'h02); io(c_CFG, 8'h00, 0, 2);
        abort = 1'b1;
        io(c_DAT, 8'h81, 1, 1);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_cs_n", cs_n, 2'b11);
        check("mid_rst_sck", sck, 0);
        check("mid_rst_mosi", mosi, 1);
        check("mid_rst_busy", busy, 0);
        rst_n = 1'b1;
        rq.push_back(8'h03); io(c_CFG, 8'h00, 0, 2);
        push_x(8'hFF, 64, 32); rq.push_back(8'hFF);
        io(c_DAT, 8'h00, 0, 1);
        wait_idle();

        repeat (3) @(negedge clk);
        check("xq_drained", xq.size(), 0);
        check("rq_drained", rq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
